uart_tx_scheduler: RTL

Round-robin scheduler that shares one `transmitter` UART instance between `N_REQ` byte-stream requesters. It sits between the transmitter's `data`/`send`/`rdy` ports and the requesting blocks, such as a status reporter, an echo path or a switch-capture path. It supports packet-level locking, so multi-byte messages are never interleaved on `txd`. It also detects a transmitter that fails to acknowledge a `send`.

---
 rtl/uart_sched_pkg.sv | 10 +
 rtl/uart_tx_scheduler_rr_pick.sv | 29 ++
 rtl/uart_tx_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and default sizing for the UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} sched_state_t;

    localparam int unsigned N_REQ_DEF        = 4;
    localparam int unsigned DATA_W_DEF       = 8;
    localparam int unsigned BUSY_TIMEOUT_DEF = 16;

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Rotating-priority selector: first valid requester strictly after ptr, wrapping mod N.
module rr_pick #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int unsigned j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req_valid[j[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter among N_REQ byte streams,
// with a watchdog on the transmitter's acknowledge of each send.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter  int unsigned N_REQ        = N_REQ_DEF,
    parameter  int unsigned DATA_W       = DATA_W_DEF,
    parameter  int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    localparam int unsigned IDX_W        = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_send,
    input  logic                      tx_rdy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              pick_found;
    logic              sel_found;
    logic              locked;
    logic              last_q;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              timeout_hit;
    logic              release_lock;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;

    rr_pick #(.N(N_REQ)) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    // While locked only the owner is eligible, even if it currently has nothing to send.
    always_comb begin
        sel_idx   = locked ? owner : pick_idx;
        sel_found = locked ? req_valid[owner] : pick_found;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_last = req_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        timeout_hit  = 1'b0;
        release_lock = 1'b0;
        tx_send      = 1'b0;
        req_ready    = '0;
        case (state)
            IDLE: begin
                if (tx_rdy && sel_found) begin
                    req_ready[sel_idx] = 1'b1;
                    accept             = 1'b1;
                    state_nxt          = ISSUE;
                end
            end
            ISSUE: begin
                tx_send   = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_rdy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_hit  = 1'b1;
                    release_lock = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_rdy) begin
                    release_lock = last_q;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= IDX_W'(N_REQ - 1);
            locked      <= 1'b0;
            owner       <= '0;
            last_q      <= 1'b0;
            tx_data     <= '0;
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (accept) begin
                tx_data <= sel_data;
                last_q  <= sel_last;
                owner   <= sel_idx;
                locked  <= 1'b1;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT_BUSY) begin
                cnt <= cnt + 1'b1;
            end
            if (release_lock) begin
                locked <= 1'b0;
                ptr    <= owner;
            end
        end
    end

    assign grant_id = owner;
    assign busy     = (state != IDLE);

endmodule
